// File: rtl/seg_scan.sv
// Four-digit multiplexed seven-segment driver. Advances one digit per rising edge of
// the slow scan input, with a fixed anode-off gap between digits and a per-frame snapshot.

module seg_digit #(
    parameter int IDX = 0,
    parameter bit LZS = 1'b0
) (
    input  logic [3:0] nib,
    input  logic       dp_req,
    input  logic       blank_req,
    input  logic       upper_zero,
    output logic [3:0] an_val,
    output logic [6:0] seg_val,
    output logic       dp_val
);
    // Digit 0 always shows something, even when the whole value is zero
    localparam bit         ZS_OK = LZS && (IDX != 0);
    localparam logic [3:0] AN_ON = ~(4'b0001 << IDX);

    logic       sup;
    logic [6:0] dec;

    always_comb begin
        dec = 7'h7F;
        case (nib)
            4'h0: dec = 7'h40;
            4'h1: dec = 7'h79;
            4'h2: dec = 7'h24;
            4'h3: dec = 7'h30;
            4'h4: dec = 7'h19;
            4'h5: dec = 7'h12;
            4'h6: dec = 7'h02;
            4'h7: dec = 7'h78;
            4'h8: dec = 7'h00;
            4'h9: dec = 7'h10;
            4'hA: dec = 7'h08;
            4'hB: dec = 7'h03;
            4'hC: dec = 7'h46;
            4'hD: dec = 7'h21;
            4'hE: dec = 7'h06;
            4'hF: dec = 7'h0E;
            default: dec = 7'h7F;
        endcase
    end

    assign sup     = blank_req | (ZS_OK & upper_zero);
    assign an_val  = sup ? 4'b1111 : AN_ON;
    assign seg_val = sup ? 7'h7F : dec;
    assign dp_val  = sup ? 1'b1 : ~dp_req;
endmodule

module seg_scan #(
    parameter logic [15:0] BLANK_CYC = 16'd100,
    parameter logic        LZS       = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        scan_in,
    input  logic [15:0] data,
    input  logic [3:0]  dp,
    input  logic [3:0]  blank,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp_out
);
    localparam int NUM_DIG = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BLANK = 2'd1;
    localparam logic [1:0] ST_SHOW  = 2'd2;

    logic [1:0]  state;
    logic [1:0]  idx;
    logic [1:0]  idx_nxt;
    logic [15:0] cnt;
    logic        s1, s2, s3;
    logic        rise;

    logic [NUM_DIG-1:0][3:0] data_snap;
    logic [NUM_DIG-1:0]      dp_snap;
    logic [NUM_DIG-1:0]      blank_snap;

    logic [NUM_DIG-1:0]      nib_zero;
    logic [NUM_DIG-1:0]      run_zero;
    logic [NUM_DIG-1:0][3:0] an_lane;
    logic [NUM_DIG-1:0][6:0] seg_lane;
    logic [NUM_DIG-1:0]      dp_lane;

    assign rise    = s2 & ~s3;
    assign idx_nxt = idx + 2'd1;

    // run_zero[i]: nibbles i..3 of the snapshot are all zero
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIG; gi++) begin : g_dig
            assign nib_zero[gi] = (data_snap[gi] == 4'h0);
            if (gi == NUM_DIG-1) begin : g_top
                assign run_zero[gi] = nib_zero[gi];
            end else begin : g_low
                assign run_zero[gi] = nib_zero[gi] & run_zero[gi+1];
            end

            seg_digit #(.IDX(gi), .LZS(LZS)) u_dig (
                .nib        (data_snap[gi]),
                .dp_req     (dp_snap[gi]),
                .blank_req  (blank_snap[gi]),
                .upper_zero (run_zero[gi]),
                .an_val     (an_lane[gi]),
                .seg_val    (seg_lane[gi]),
                .dp_val     (dp_lane[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1         <= 1'b0;
            s2         <= 1'b0;
            s3         <= 1'b0;
            state      <= ST_IDLE;
            idx        <= 2'd3;
            cnt        <= 16'd0;
            data_snap  <= '0;
            dp_snap    <= '0;
            blank_snap <= '0;
            an         <= 4'b1111;
            seg        <= 7'h7F;
            dp_out     <= 1'b1;
        end else begin
            s1 <= scan_in;
            s2 <= s1;
            s3 <= s2;
            case (state)
                ST_IDLE, ST_SHOW: begin
                    if (rise) begin
                        state  <= ST_BLANK;
                        idx    <= idx_nxt;
                        an     <= 4'b1111;
                        seg    <= 7'h7F;
                        dp_out <= 1'b1;
                        cnt    <= BLANK_CYC - 16'd1;
                        // Frame boundary: freeze inputs so a frame never mixes old and new digits
                        if (idx_nxt == 2'd0) begin
                            data_snap  <= data;
                            dp_snap    <= dp;
                            blank_snap <= blank;
                        end
                    end
                end
                ST_BLANK: begin
                    if (cnt == 16'd0) begin
                        state  <= ST_SHOW;
                        an     <= an_lane[idx];
                        seg    <= seg_lane[idx];
                        dp_out <= dp_lane[idx];
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seg_scan.sv
// Directed bench for seg_scan: two instances (LZS off/on) share stimulus, BLANK_CYC=4.

module tb_seg_scan;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        scan_in = 1'b0;
    logic [15:0] data = 16'h0000;
    logic [3:0]  dp = 4'h0;
    logic [3:0]  blank = 4'h0;
    logic [3:0]  an0, an1;
    logic [6:0]  seg0, seg1;
    logic        dpo0, dpo1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seg_scan #(.BLANK_CYC(16'd4), .LZS(1'b0)) dut (
        .clk(clk), .reset(reset), .scan_in(scan_in), .data(data), .dp(dp), .blank(blank),
        .an(an0), .seg(seg0), .dp_out(dpo0)
    );

    seg_scan #(.BLANK_CYC(16'd4), .LZS(1'b1)) dut_lzs (
        .clk(clk), .reset(reset), .scan_in(scan_in), .data(data), .dp(dp), .blank(blank),
        .an(an1), .seg(seg1), .dp_out(dpo1)
    );

    // One scan_in pulse; returns settled outputs of both DUTs plus timing of dut.
    // lat: negedges from raising scan_in until dut lights (-1 if never);
    // offc: cycles dut was dark before lighting.
    task automatic scan_step(output logic [3:0] a0, output logic [6:0] g0, output logic d0,
                             output logic [3:0] a1, output logic [6:0] g1, output logic d1,
                             output int lat, output int offc);
        int first_off;
        first_off = -1;
        lat = -1;
        @(negedge clk);
        scan_in = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (first_off < 0 && an0 == 4'hF) first_off = k;
            if (lat < 0 && first_off >= 0 && an0 != 4'hF) lat = k;
        end
        offc = (lat > 0) ? lat - first_off : -1;
        a0 = an0; g0 = seg0; d0 = dpo0;
        a1 = an1; g1 = seg1; d1 = dpo1;
        scan_in = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset();
        int lit;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            scan_in = ~scan_in;
            checks++;
            if ({an0, seg0, dpo0} !== {4'hF, 7'h7F, 1'b1}) begin
                errors++;
                $display("FAIL reset_hold cyc %0d: an=%b seg=%h dp=%b, want 1111/7f/1", i, an0, seg0, dpo0);
            end
        end
        scan_in = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        lit = 0;
        repeat (10) begin
            @(negedge clk);
            if (an0 != 4'hF || an1 != 4'hF) lit++;
        end
        checks++;
        if (lit !== 0) begin
            errors++;
            $display("FAIL reset_idle: lit samples=%0d, want 0", lit);
        end
    endtask

    task automatic test_scan_order();
        logic [3:0] a0, a1; logic [6:0] g0, g1; logic d0, d1; int lat, offc;
        logic [3:0] exp_an [5] = '{4'hE, 4'hD, 4'hB, 4'h7, 4'hE};
        logic [6:0] exp_seg[5] = '{7'h19, 7'h30, 7'h24, 7'h79, 7'h19};
        data = 16'h1234; dp = 4'h0; blank = 4'h0;
        for (int i = 0; i < 5; i++) begin
            scan_step(a0, g0, d0, a1, g1, d1, lat, offc);
            checks++;
            if ({a0, g0, d0} !== {exp_an[i], exp_seg[i], 1'b1}) begin
                errors++;
                $display("FAIL order step %0d: an=%b seg=%h dp=%b, want %b/%h/1", i, a0, g0, d0, exp_an[i], exp_seg[i]);
            end
            checks++;
            if (lat !== 7) begin
                errors++;
                $display("FAIL order_latency step %0d: got %0d, want 7", i, lat);
            end
            if (i > 0) begin
                checks++;
                if (offc !== 4) begin
                    errors++;
                    $display("FAIL order_blank_gap step %0d: got %0d, want 4", i, offc);
                end
            end
        end
    endtask

    task automatic test_tear_free();
        logic [3:0] a0, a1; logic [6:0] g0, g1; logic d0, d1; int lat, offc;
        logic [3:0] exp_an [7] = '{4'hD, 4'hB, 4'h7, 4'hE, 4'hD, 4'hB, 4'h7};
        logic [6:0] exp_seg[7] = '{7'h30, 7'h24, 7'h79, 7'h21, 7'h46, 7'h03, 7'h08};
        for (int i = 0; i < 7; i++) begin
            scan_step(a0, g0, d0, a1, g1, d1, lat, offc);
            if (i == 1) data = 16'hABCD;
            checks++;
            if ({a0, g0} !== {exp_an[i], exp_seg[i]}) begin
                errors++;
                $display("FAIL tear_free step %0d: an=%b seg=%h, want %b/%h", i, a0, g0, exp_an[i], exp_seg[i]);
            end
        end
    endtask

    task automatic test_lzs();
        logic [3:0] a0, a1; logic [6:0] g0, g1; logic d0, d1; int lat, offc;
        logic [3:0] exp_an [8] = '{4'hE, 4'hD, 4'hF, 4'hF, 4'hE, 4'hF, 4'hF, 4'hF};
        logic [6:0] exp_seg[8] = '{7'h40, 7'h12, 7'h7F, 7'h7F, 7'h40, 7'h7F, 7'h7F, 7'h7F};
        data = 16'h0050;
        for (int i = 0; i < 8; i++) begin
            scan_step(a0, g0, d0, a1, g1, d1, lat, offc);
            if (i == 3) data = 16'h0000;
            checks++;
            if ({a1, g1, d1} !== {exp_an[i], exp_seg[i], 1'b1}) begin
                errors++;
                $display("FAIL lzs step %0d: an=%b seg=%h dp=%b, want %b/%h/1", i, a1, g1, d1, exp_an[i], exp_seg[i]);
            end
            if (i == 2) begin
                checks++;
                if ({a0, g0} !== {4'hB, 7'h40}) begin
                    errors++;
                    $display("FAIL no_lzs_digit2: an=%b seg=%h, want 1011/40", a0, g0);
                end
            end
        end
    endtask

    task automatic test_masks();
        logic [3:0] a0, a1; logic [6:0] g0, g1; logic d0, d1; int lat, offc;
        logic [3:0] exp_an [4] = '{4'hE, 4'hD, 4'hF, 4'h7};
        logic [6:0] exp_seg[4] = '{7'h00, 7'h00, 7'h7F, 7'h00};
        logic       exp_dp [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        data = 16'h8888; blank = 4'b0100; dp = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            scan_step(a0, g0, d0, a1, g1, d1, lat, offc);
            checks++;
            if ({a0, g0, d0} !== {exp_an[i], exp_seg[i], exp_dp[i]}) begin
                errors++;
                $display("FAIL masks step %0d: an=%b seg=%h dp=%b, want %b/%h/%b", i, a0, g0, d0, exp_an[i], exp_seg[i], exp_dp[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] a0, a1; logic [6:0] g0, g1; logic d0, d1; int lat, offc;
        data = 16'h1234; blank = 4'h0; dp = 4'h0;
        for (int i = 0; i < 3; i++) scan_step(a0, g0, d0, a1, g1, d1, lat, offc);
        checks++;
        if ({a0, g0} !== {4'hB, 7'h24}) begin
            errors++;
            $display("FAIL rmid_digit2: an=%b seg=%h, want 1011/24", a0, g0);
        end
        data = 16'h5678;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({an0, seg0, dpo0} !== {4'hF, 7'h7F, 1'b1}) begin
            errors++;
            $display("FAIL rmid_off: an=%b seg=%h dp=%b, want 1111/7f/1", an0, seg0, dpo0);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        scan_step(a0, g0, d0, a1, g1, d1, lat, offc);
        checks++;
        if ({a0, g0} !== {4'hE, 7'h00}) begin
            errors++;
            $display("FAIL rmid_first: an=%b seg=%h, want 1110/00", a0, g0);
        end
        scan_step(a0, g0, d0, a1, g1, d1, lat, offc);
        checks++;
        if ({a0, g0} !== {4'hD, 7'h78}) begin
            errors++;
            $display("FAIL rmid_second: an=%b seg=%h, want 1101/78", a0, g0);
        end
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_scan_order();
        test_tear_free();
        test_lzs();
        test_masks();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
